// File: rtl/mem_reader_pkg.sv
// Shared types and constants for the RAM scan reader.
package mem_reader_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_CAPT  = 2'd2,
    ST_DWELL = 2'd3
  } state_e;

  localparam int KEY_PAUSE   = 0;
  localparam int KEY_STEP    = 1;
  localparam int KEY_RESTART = 2;
  localparam int NUM_KEYS    = 3;

  localparam int CNT_W = 26;
endpackage

// File: rtl/mem_reader_if.sv
// Read port of the shared 16x8 synchronous RAM.
// Handshake: req is held with a stable until an edge where req && gnt; dout is valid one edge later.
interface mem_reader_if;
  logic       req;
  logic       gnt;
  logic [3:0] a;
  logic [7:0] dout;

  modport master (output req, output a, input gnt, input dout);
  modport slave  (input req, input a, output gnt, output dout);
endinterface

// File: rtl/mem_reader_key_event.sv
// One pushbutton: 2-flop synchronizer plus a one-cycle pulse on the synchronized falling edge.
module key_event (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic ev
);
  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = key_n;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Released buttons read 1, so reset to 1 to avoid a spurious event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign ev = s3_q & ~s2_q;
endmodule

// File: rtl/mem_reader.sv
// Scans RAM addresses 0..15, holding each address and its data for DWELL cycles,
// with pause, single-step and restart pushbuttons.
module mem_reader
  import mem_reader_pkg::*;
#(
  parameter int unsigned DWELL = 25000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         KEY,
  mem_reader_if.master       ram,
  output logic [3:0]         addr_q,
  output logic [7:0]         data_q,
  output logic               data_valid,
  output logic               paused,
  output state_e             dbg_state
);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  logic [NUM_KEYS-1:0] ev;
  logic                unused_key;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [3:0]       addr_d;
  logic [7:0]       data_d;
  logic             valid_q, valid_d;
  logic             paused_q, paused_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             advance;

  assign unused_key = KEY[3];

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_event u_key (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (KEY[k]),
      .ev    (ev[k])
    );
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    paused_d = paused_q ^ ev[KEY_PAUSE];
    advance  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        req_d   = 1'b1;
      end
      ST_REQ: begin
        // After a restart req is still low here, so a grant this cycle is not ours.
        if (req_q && ram.gnt) begin
          state_d = ST_CAPT;
          req_d   = 1'b0;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_CAPT: begin
        data_d  = ram.dout;
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = ST_DWELL;
      end
      ST_DWELL: begin
        if (paused_q) begin
          advance = ev[KEY_STEP] & ~ev[KEY_PAUSE];
        end else if (cnt_q == DWELL_LAST) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      addr_d  = addr_q + 4'd1;
      valid_d = 1'b0;
      req_d   = 1'b1;
      state_d = ST_REQ;
    end

    if (ev[KEY_RESTART]) begin
      addr_d  = '0;
      data_d  = data_q;
      valid_d = 1'b0;
      cnt_d   = '0;
      req_d   = 1'b0;
      state_d = ST_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      paused_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      paused_q <= paused_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ram.req    = req_q;
  assign ram.a      = addr_q;
  assign data_valid = valid_q;
  assign paused     = paused_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_mem_reader.sv
// Directed bench for mem_reader with DWELL=4 and a RAM model holding mem[i]=0x10+i.
module tb_mem_reader;
  import mem_reader_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] KEY;
  logic [3:0] addr_q;
  logic [7:0] data_q;
  logic       data_valid;
  logic       paused;
  state_e     dbg_state;
  logic [7:0] mem [16];
  int         tests;
  int         fails;

  mem_reader_if bus ();

  mem_reader #(.DWELL(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .KEY        (KEY),
    .ram        (bus),
    .addr_q     (addr_q),
    .data_q     (data_q),
    .data_valid (data_valid),
    .paused     (paused),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data for a granted edge appears on dout at that edge
  always @(posedge clk) begin
    if (bus.req && bus.gnt) bus.dout <= mem[bus.a];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int idx);
    KEY[idx] = 1'b0;
    repeat (3) @(negedge clk);
    KEY[idx] = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_valid_at(input logic [3:0] ad, input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (addr_q == ad && data_valid) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_state(input state_e st, input logic [3:0] ad, input int budget,
                            input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (dbg_state == st && addr_q == ad) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   32'(bus.req),    32'd0);
    check({tag, "_a"},     32'(bus.a),      32'd0);
    check({tag, "_addr"},  32'(addr_q),     32'd0);
    check({tag, "_data"},  32'(data_q),     32'h00);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_pause"}, 32'(paused),     32'd0);
    check({tag, "_state"}, 32'(dbg_state),  32'(ST_IDLE));
  endtask

  initial begin
    bit stall_ok;
    tests = 0;
    fails = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    rst_n   = 1'b0;
    KEY     = 4'hF;
    bus.gnt = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("rst");

    // First transaction: exact latencies
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 32'(bus.req), 32'd1);
    check("first_st_req", 32'(dbg_state), 32'(ST_REQ));
    @(negedge clk);
    check("capt_req_low", 32'(bus.req), 32'd0);
    check("capt_valid_low", 32'(data_valid), 32'd0);
    @(negedge clk);
    check("first_data", 32'(data_q), 32'h10);
    check("first_valid", 32'(data_valid), 32'd1);
    repeat (3) @(negedge clk);
    check("dwell_hold_addr", 32'(addr_q), 32'd0);
    @(negedge clk);
    check("dwell_adv_addr", 32'(addr_q), 32'd1);
    check("a_follows_addr", 32'(bus.a), 32'd1);
    check("adv_valid_low", 32'(data_valid), 32'd0);

    // Full scan and wrap
    wait_valid_at(4'd15, 120, "reach_15");
    check("data_15", 32'(data_q), 32'h1F);
    wait_valid_at(4'd0, 20, "wrap_0");
    check("wrap_data", 32'(data_q), 32'h10);

    // Grant withheld for 10 cycles in REQ
    bus.gnt = 1'b0;
    wait_state(ST_REQ, 4'd1, 20, "stall_enter");
    stall_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(bus.req === 1'b1 && bus.a === 4'd1 && data_valid === 1'b0 && dbg_state === ST_REQ))
        stall_ok = 1'b0;
    end
    check("stall_hold", 32'(stall_ok), 32'd1);
    bus.gnt = 1'b1;
    wait_valid_at(4'd1, 10, "stall_done");
    check("stall_data", 32'(data_q), 32'h11);

    // Pause at address 3, then single step
    wait_valid_at(4'd3, 40, "reach_3");
    press(KEY_PAUSE);
    check("paused_set", 32'(paused), 32'd1);
    repeat (50) @(negedge clk);
    check("pause_addr", 32'(addr_q), 32'd3);
    check("pause_valid", 32'(data_valid), 32'd1);
    check("pause_state", 32'(dbg_state), 32'(ST_DWELL));
    press(KEY_STEP);
    wait_valid_at(4'd4, 10, "step_addr");
    check("step_data", 32'(data_q), 32'h14);
    check("step_still_paused", 32'(paused), 32'd1);
    repeat (10) @(negedge clk);
    check("step_hold_addr", 32'(addr_q), 32'd4);

    // Step together with pause toggle: step ignored, scan resumes
    KEY[KEY_PAUSE] = 1'b0;
    KEY[KEY_STEP]  = 1'b0;
    repeat (3) @(negedge clk);
    check("combo_addr", 32'(addr_q), 32'd4);
    check("combo_unpaused", 32'(paused), 32'd0);
    check("combo_state", 32'(dbg_state), 32'(ST_DWELL));
    KEY = 4'hF;

    // Restart landing on the CAPT edge at address 7
    wait_valid_at(4'd6, 40, "reach_6");
    check("data_6", 32'(data_q), 32'h16);
    bus.gnt = 1'b0;
    wait_state(ST_REQ, 4'd7, 20, "reach_req_7");
    KEY[KEY_RESTART] = 1'b0;
    @(negedge clk);
    bus.gnt = 1'b1;
    @(negedge clk);
    check("rs_in_capt", 32'(dbg_state), 32'(ST_CAPT));
    @(negedge clk);
    check("rs_data_kept", 32'(data_q), 32'h16);
    check("rs_valid", 32'(data_valid), 32'd0);
    check("rs_addr", 32'(addr_q), 32'd0);
    check("rs_state", 32'(dbg_state), 32'(ST_REQ));
    check("rs_req_low", 32'(bus.req), 32'd0);
    check("rs_paused", 32'(paused), 32'd0);
    @(negedge clk);
    check("rs_req_high", 32'(bus.req), 32'd1);
    KEY[KEY_RESTART] = 1'b1;
    wait_valid_at(4'd0, 10, "rs_regrant");
    check("rs_data_0", 32'(data_q), 32'h10);

    // Asynchronous reset during DWELL at address 9 while paused
    wait_valid_at(4'd9, 80, "reach_9");
    press(KEY_PAUSE);
    check("pre_rst_paused", 32'(paused), 32'd1);
    check("pre_rst_addr", 32'(addr_q), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 Parameter DWELL, default 25000000, SHALL set cycles spent displaying each address; legal range 2..2^26-1.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 KEY  input  4  raw active-low pushbuttons: KEY[0] pause/resume toggle, KEY[1] single-step while paused, KEY[2] restart at address 0, KEY[3] unused.
REQ-005 req  output  1  request for the 16x8 synchronous RAM read port.
REQ-006 gnt  input  1  RAM port granted to this block this cycle; the write controller has priority.
REQ-007 a  output  4  RAM address; SHALL equal addr_q at all times.
REQ-008 dout  input  8  RAM read data, valid one edge after a granted edge.
REQ-009 addr_q  output  4  address currently displayed.
REQ-010 data_q  output  8  data captured for addr_q.
REQ-011 data_valid  output  1  data_q corresponds to addr_q.
REQ-012 paused  output  1  automatic scan halted.

Function
REQ-013 States SHALL be IDLE, REQ, CAPT and DWELL.
REQ-014 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-015 REQ: req=1 with a stable; an edge with gnt=1 SHALL go to CAPT; gnt=0 SHALL hold REQ indefinitely.
REQ-016 CAPT: req=0; on the next edge data_q<=dout, data_valid<=1, dwell counter<=0, go to DWELL (granted edge to data_q update = 2 edges).
REQ-017 DWELL, not paused: the counter SHALL increment each cycle; at DWELL-1 it SHALL set addr_q<=addr_q+1 (15 wraps to 0), data_valid<=0, go to REQ.
REQ-018 DWELL, paused: the counter SHALL freeze; a step event SHALL advance the address as in REQ-017 and go to REQ.
REQ-019 Key events SHALL be one-cycle pulses on the synchronized falling edge of each KEY; a held key SHALL give exactly one event.
REQ-020 Pause event SHALL toggle paused in any state; the toggle SHALL take effect in DWELL only.
REQ-021 Step event outside DWELL, or while not paused, SHALL be ignored.
REQ-022 Restart event in any state SHALL set addr_q=0, data_valid=0, counter=0, req=0 and go to REQ next cycle; paused SHALL be unchanged.
REQ-023 Simultaneous events: restart SHALL override step and advance; a step coinciding with a pause toggle SHALL be ignored.
REQ-024 gnt while req=0 SHALL be ignored.
REQ-025 The block SHALL never drive any RAM write signal.

Reset
REQ-026 While rst_n=0: state=IDLE, req=0, addr_q=0, a=0, data_q=0x00, data_valid=0, paused=0, counter=0, synchronizer flops=1 (released).
REQ-027 Reset asserted mid-transaction SHALL abort it without any data_q update.

Structure
REQ-028 A shared package SHALL hold the state enum and the KEY bit-index constants.
REQ-029 One sub-module, key_event (2-flop synchronizer plus falling-edge pulse, one bit), SHALL be instantiated for KEY[2:0].

Verification (DWELL=4, RAM preloaded mem[i]=0x10+i)
REQ-030 Reset release, gnt tied 1 -> req high 1 cycle after IDLE; data_q=0x10, data_valid=1 two edges after grant; addr_q=1 four cycles later.
REQ-031 Run through address 15 -> addr_q wraps to 0, data_q=0x10 again.
REQ-032 gnt held 0 for 10 cycles in REQ -> req stays 1, a stable, data_valid=0; grant then completes normally.
REQ-033 Pause in DWELL at addr 3 -> addr_q held 3 for 50 cycles; step -> addr_q=4, data_q=0x14; step and pause pressed together -> step ignored.
REQ-034 Restart during CAPT at addr 7 -> data_q not updated; next grant gives addr_q=0, data_q=0x10.
REQ-035 rst_n low during DWELL at addr 9 -> all outputs return to REQ-026 values asynchronously.
